// File: rtl/dvp_frame_source.sv
// OV7670-style DVP camera emulator: vsync/href framing with RGB565 test patterns,
// two bytes per pixel, high byte first. All outputs registered.
module dvp_frame_source #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 144,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BACK   = 17,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int unsigned LINE   = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned BYTE_W = $clog2(LINE);
  localparam int unsigned MAX_A  = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int unsigned MAX_B  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned MAX_L  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned LINE_W = $clog2(MAX_L + 1);
  localparam int unsigned BAR_PX = H_ACTIVE / 8;
  localparam int unsigned BAR_W  = $clog2(BAR_PX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_t;

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [BAR_W-1:0]    bar_px_q, bar_px_d;
  logic [2:0]          bar_idx_q, bar_idx_d;
  logic [7:0]          ramp_q, ramp_d;
  logic [1:0]          pat_q, pat_d;
  logic                frame_done;
  logic                vsync_d, href_d, busy_d;
  logic [7:0]          data_d;
  logic [7:0]          x8, y8;
  logic [15:0]         pix;

  // Index of the final line in each timed state.
  function automatic logic [LINE_W-1:0] last_line_of(input state_t s);
    case (s)
      ST_VSYNC:  last_line_of = LINE_W'(V_SYNC - 1);
      ST_VBACK:  last_line_of = LINE_W'(V_BACK - 1);
      ST_ACTIVE: last_line_of = LINE_W'(V_ACTIVE - 1);
      ST_VFRONT: last_line_of = LINE_W'(V_FRONT - 1);
      default:   last_line_of = '0;
    endcase
  endfunction

  function automatic logic [15:0] bar_colour(input logic [2:0] b);
    case (b)
      3'd0:    bar_colour = 16'hFFFF;
      3'd1:    bar_colour = 16'hFFE0;
      3'd2:    bar_colour = 16'h07FF;
      3'd3:    bar_colour = 16'h07E0;
      3'd4:    bar_colour = 16'hF81F;
      3'd5:    bar_colour = 16'hF800;
      3'd6:    bar_colour = 16'h001F;
      default: bar_colour = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      byte_q      <= '0;
      line_q      <= '0;
      bar_px_q    <= '0;
      bar_idx_q   <= '0;
      ramp_q      <= '0;
      pat_q       <= '0;
      vsync       <= 1'b0;
      href        <= 1'b0;
      data        <= 8'h00;
      busy        <= 1'b0;
      frame_count <= '0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      line_q      <= line_d;
      bar_px_q    <= bar_px_d;
      bar_idx_q   <= bar_idx_d;
      ramp_q      <= ramp_d;
      pat_q       <= pat_d;
      vsync       <= vsync_d;
      href        <= href_d;
      data        <= data_d;
      busy        <= busy_d;
      if (frame_done) frame_count <= frame_count + 16'd1;
    end
  end

  // Next-state, counters, and the output values for the upcoming cycle.
  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    line_d     = line_q;
    bar_px_d   = bar_px_q;
    bar_idx_d  = bar_idx_q;
    ramp_d     = ramp_q;
    pat_d      = pat_q;
    frame_done = 1'b0;
    data_d     = 8'h00;
    pix        = 16'h0000;

    if (state_q == ST_IDLE) begin
      if (enable) begin
        state_d = ST_VSYNC;
        byte_d  = '0;
        line_d  = '0;
      end
    end else if (byte_q == BYTE_W'(LINE - 1)) begin
      byte_d = '0;
      if (line_q == last_line_of(state_q)) begin
        line_d = '0;
        case (state_q)
          ST_VSYNC:  state_d = ST_VBACK;
          ST_VBACK:  state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_VFRONT;
          default: begin
            frame_done = 1'b1;
            state_d    = enable ? ST_VSYNC : ST_IDLE;
          end
        endcase
      end else begin
        line_d = line_q + LINE_W'(1);
      end
    end else begin
      byte_d = byte_q + BYTE_W'(1);
    end

    if (state_d == ST_VSYNC && state_q != ST_VSYNC) begin
      pat_d  = pattern;
      ramp_d = 8'h00;
    end

    // Bar index advances every BAR_PX pixels; restarts at each line start.
    if (byte_d == '0) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (byte_q[0]) begin
      if (bar_px_q == BAR_W'(BAR_PX - 1)) begin
        bar_px_d  = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_px_d = bar_px_q + BAR_W'(1);
      end
    end

    vsync_d = (state_d == ST_VSYNC);
    busy_d  = (state_d != ST_IDLE);
    href_d  = (state_d == ST_ACTIVE) && (byte_d < BYTE_W'(2 * H_ACTIVE));

    x8 = 8'(byte_d >> 1);
    y8 = 8'(line_d);
    case (pat_d)
      2'd0:    pix = {x8, y8};
      2'd1:    pix = bar_colour(bar_idx_d);
      default: pix = 16'hA55A;
    endcase

    if (href_d) begin
      ramp_d = ramp_q + 8'd1;
      if (pat_d == 2'd2) data_d = ramp_q;
      else               data_d = byte_d[0] ? pix[7:0] : pix[15:8];
    end
  end

endmodule
